divisor_sequencial: RTL

Iterative 32-bit signed divider for the multicycle MIPS datapath. It sits directly downstream of the control unit. It is started by DIVCtrl and reports divZero back to the FSM. It produces quotient/remainder for the LO/HI registers that MFLO/MFHI read. It computes one quotient bit per clock using restoring division on operand magnitudes, then applies a sign fix-up.

---
 rtl/divisor_sequencial_if.sv | 33 +++
 rtl/divisor_sequencial.sv | 123 ++++++++++++
 2 files changed

// File: rtl/divisor_sequencial_if.sv
// Handshake and operand/result bundle between the control unit (master) and the divider (slave).
// When DIVU_EN is defined an extra Unsigned select travels with the operands.
interface divisor_sequencial_if #(
    parameter int WIDTH = 32
);
    logic             DIVCtrl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             divZero;
    logic             DivDone;
    logic             busy;
`ifdef DIVU_EN
    logic             Unsigned;
`endif

    modport master (
        output DIVCtrl, A, B,
`ifdef DIVU_EN
        output Unsigned,
`endif
        input  HI, LO, divZero, DivDone, busy
    );

    modport slave (
        input  DIVCtrl, A, B,
`ifdef DIVU_EN
        input  Unsigned,
`endif
        output HI, LO, divZero, DivDone, busy
    );
endinterface

// File: rtl/divisor_sequencial.sv
// Iterative signed restoring divider: one quotient bit per clock on operand magnitudes, then sign fix-up.
// Optional macro DIVU_EN adds an Unsigned select sampled with the operands.
module divisor_sequencial #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    divisor_sequencial_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, CALC, FIX, ZERO, WAIT_LOW} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_count;
    logic             r_signQ;
    logic             r_signR;
    logic             r_divZero;
    logic             r_divDone;
    logic             r_busy;

    logic             w_isUnsigned;
    logic [WIDTH-1:0] w_magA;
    logic [WIDTH-1:0] w_magB;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;

`ifdef DIVU_EN
    assign w_isUnsigned = bus.Unsigned;
`else
    assign w_isUnsigned = 1'b0;
`endif

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign w_magA = (!w_isUnsigned && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign w_magB = (!w_isUnsigned && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // The extra top bit of the trial difference acts as its sign: set means the divisor did not fit.
    assign w_shifted = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, r_divisor};

    assign bus.HI      = r_hi;
    assign bus.LO      = r_lo;
    assign bus.divZero = r_divZero;
    assign bus.DivDone = r_divDone;
    assign bus.busy    = r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_count   <= '0;
            r_signQ   <= 1'b0;
            r_signR   <= 1'b0;
            r_divZero <= 1'b0;
            r_divDone <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_divZero <= 1'b0;
            r_divDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.DIVCtrl) begin
                        r_busy <= 1'b1;
                        if (bus.B == '0) begin
                            r_state <= ZERO;
                        end else begin
                            r_quo     <= w_magA;
                            r_divisor <= w_magB;
                            r_rem     <= '0;
                            r_signQ   <= !w_isUnsigned && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            r_signR   <= !w_isUnsigned && bus.A[WIDTH-1];
                            r_count   <= CW'(WIDTH - 1);
                            r_state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shifted[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    if (r_count == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                FIX: begin
                    r_lo      <= r_signQ ? -r_quo : r_quo;
                    r_hi      <= r_signR ? -r_rem : r_rem;
                    r_divDone <= 1'b1;
                    r_state   <= WAIT_LOW;
                end
                ZERO: begin
                    r_divZero <= 1'b1;
                    r_state   <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!bus.DIVCtrl) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
